pc_predict_unit: RTL and testbench
==================================

// Module: pc_predict_unit
// PURPOSE
//  Fetch-stage program counter with next-PC selection and a direct-mapped branch target buffer (BTB).
//  Each cycle it selects the next PC by priority: exception, EX-stage redirect, stall hold,
//  BTB-predicted target, then sequential PC+4.
//  The BTB is trained from EX-stage branch resolution.
//  It sits in IF, drives the instruction-memory address and the IF/ID PC fields, and takes control from hazard/EX/exception logic.
// PARAMETERS
//  WIDTH        32            PC width in bits (>= 8)
//  RESET_VECTOR 32'h00000000  PC value loaded by reset
//  EXC_VECTOR   32'h80000004  PC value loaded on exc_req
//  BTB_ENTRIES  8             number of BTB entries; power of 2, >= 2; IDX = log2(BTB_ENTRIES)
// PORTS
//  clk            input   1      clock; all state updates on rising edge
//  rst            input   1      synchronous reset, active-low (0 = reset, sampled at posedge clk)
//  stall          input   1      hold PC (load-use / memory hazard)
//  exc_req        input   1      exception/interrupt: load EXC_VECTOR
//  redirect_valid input   1      EX mispredict correction
//  redirect_pc    input   WIDTH  correct next PC for redirect
//  upd_valid      input   1      EX resolved a branch/jump this cycle
//  upd_pc         input   WIDTH  PC of the resolved branch
//  upd_target     input   WIDTH  resolved taken target
//  upd_taken      input   1      resolved direction
//  pc             output  WIDTH  current fetch PC (registered)
//  pc4            output  WIDTH  pc + 4, modulo 2^WIDTH
//  pred_taken     output  1      BTB predicts taken for pc
//  pred_target    output  WIDTH  predicted target; equals pc4 when pred_taken = 0
// BEHAVIOUR
//  - Reset (rst=0 at posedge): pc <= RESET_VECTOR; all BTB valid bits <= 0; training is blocked that cycle.
//    Reset overrides every other input, including mid-stall, mid-redirect and a concurrent update.
//  - Next-PC priority, registered at posedge (1-cycle latency):
//      exc_req -> EXC_VECTOR
//      redirect_valid -> redirect_pc
//      stall -> pc held
//      pred_taken -> pred_target
//      otherwise -> pc4
//    exc_req and redirect_valid override stall.
//    If exc_req and redirect_valid are both high, EXC_VECTOR wins.
//  - pc4 wraps: pc = {WIDTH{1'b1}} & ~3 gives pc4 = 0.
//    No alignment check is made; redirect_pc is loaded verbatim.
//  - BTB entry fields: valid, tag = PC[WIDTH-1:IDX+2], target[WIDTH-1:0], ctr[1:0] (2-bit saturating counter).
//    Index = PC[IDX+1:2]; PC[1:0] is ignored.
//  - Lookup is combinational from pc and BTB registers: hit = valid && tag match.
//    pred_taken = hit && ctr[1]. pred_target = entry target when pred_taken, else pc4.
//  - Update on upd_valid at posedge, indexed by upd_pc:
//      hit, taken: ctr = min(ctr+1, 3); target <= upd_target.
//      hit, not taken: ctr = max(ctr-1, 0); target kept.
//      miss, taken: allocate, overwriting any entry: valid=1, tag, target, ctr=2'b10.
//      miss, not taken: no change.
//  - Lookup and update on the same index in the same cycle: the lookup uses pre-update contents (no bypass).
//    The new contents are visible from the next cycle.
//  - Training is independent of stall, exc_req and redirect_valid; only reset blocks it.
//  - pred_taken and pred_target are valid whenever rst=1, including while stalled.
// TESTING
//  1. rst=0 for 2 cycles, then rst=1, no control inputs -> pc = 0, 4, 8, 12 on successive cycles;
//     pred_taken = 0 throughout.
//  2. At pc=0x10, assert stall for 3 cycles with redirect_valid=1, redirect_pc=0x40 in the 2nd cycle
//     -> pc holds 0x10, 0x10, then 0x40; pc stays 0x40 while stall remains high.
//  3. exc_req=1 and redirect_valid=1 (redirect_pc=0x100) in the same cycle -> next pc = EXC_VECTOR (0x80000004).
//  4. Train upd_pc=0x20, upd_target=0x80, upd_taken=1, then sequential fetch reaches 0x20
//     -> pred_taken=1, pred_target=0x80, next pc=0x80.
//     Then two not-taken updates to 0x20 -> at 0x20 pred_taken=0, next pc=0x24.
//  5. Aliasing with BTB_ENTRIES=8: train taken for 0x20 (target 0x80), then taken for 0x40 (same index, target 0xC0)
//     -> fetch at 0x20 gives pred_taken=0; fetch at 0x40 gives pred_target=0xC0.
//  6. Set pc=0xFFFFFFFC via redirect -> pc4=0 and next pc=0.
//     Then drive rst=0 concurrently with upd_valid=1 -> pc=0 and the BTB is empty (no prediction at the trained PC).

Source files
------------

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: fetch-stage PC register with priority next-PC select and a direct-mapped BTB
module pc_predict_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h80000004,
    parameter int               BTB_ENTRIES  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_exc_req,
    input  logic             i_redirect_valid,
    input  logic [WIDTH-1:0] i_redirect_pc,
    input  logic             i_upd_valid,
    input  logic [WIDTH-1:0] i_upd_pc,
    input  logic [WIDTH-1:0] i_upd_target,
    input  logic             i_upd_taken,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc4,
    output logic             o_pred_taken,
    output logic [WIDTH-1:0] o_pred_target
);
    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = WIDTH - IDX - 2;

    logic [WIDTH-1:0]       r_pc;
    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TW-1:0]          r_tag [BTB_ENTRIES];
    logic [WIDTH-1:0]       r_tgt [BTB_ENTRIES];
    logic [1:0]             r_ctr [BTB_ENTRIES];

    logic [IDX-1:0]   w_idx;
    logic [IDX-1:0]   w_uidx;
    logic             w_hit;
    logic             w_uhit;
    logic             w_pred;
    logic [WIDTH-1:0] w_pc4;
    logic [WIDTH-1:0] w_next;
    logic             w_unused;

    // The low two PC bits never select or tag a BTB entry.
    assign w_unused = &{1'b0, i_upd_pc[1:0]};

    // Lookup for the fetch PC, hit test for the training PC, and the next-PC priority chain.
    always_comb begin
        w_idx  = r_pc[IDX+1:2];
        w_pc4  = r_pc + WIDTH'(4);
        w_hit  = r_valid[w_idx] && (r_tag[w_idx] == r_pc[WIDTH-1:IDX+2]);
        w_pred = w_hit && r_ctr[w_idx][1];
        w_uidx = i_upd_pc[IDX+1:2];
        w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == i_upd_pc[WIDTH-1:IDX+2]);
        w_next = i_exc_req        ? EXC_VECTOR    :
                 i_redirect_valid ? i_redirect_pc :
                 i_stall          ? r_pc          :
                 w_pred           ? r_tgt[w_idx]  : w_pc4;
    end

    // PC register and valid bits; reset clears every entry so stale contents are never trusted.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pc    <= RESET_VECTOR;
            r_valid <= '0;
        end else begin
            r_pc <= w_next;
            if (i_upd_valid && i_upd_taken && !w_uhit)
                r_valid[w_uidx] <= 1'b1;
        end
    end

    // Entry payload training: saturating counter on a hit, fresh weakly-taken allocation on a taken miss.
    always_ff @(posedge i_clk) begin
        if (i_rst && i_upd_valid) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= i_upd_taken ? ((r_ctr[w_uidx] == 2'd3) ? 2'd3 : r_ctr[w_uidx] + 2'd1)
                                             : ((r_ctr[w_uidx] == 2'd0) ? 2'd0 : r_ctr[w_uidx] - 2'd1);
                if (i_upd_taken)
                    r_tgt[w_uidx] <= i_upd_target;
            end else if (i_upd_taken) begin
                r_tag[w_uidx] <= i_upd_pc[WIDTH-1:IDX+2];
                r_tgt[w_uidx] <= i_upd_target;
                r_ctr[w_uidx] <= 2'b10;
            end
        end
    end

    assign o_pc          = r_pc;
    assign o_pc4         = w_pc4;
    assign o_pred_taken  = w_pred;
    assign o_pred_target = w_pred ? r_tgt[w_idx] : w_pc4;
endmodule

// File: tb/tb_pc_predict_unit.sv
// tb_pc_predict_unit: vector table, directed corner sequences and random traffic against a BTB model
module tb_pc_predict_unit;
    logic        clk = 0, rst = 0, stall = 0, exc = 0, rv = 0, uv = 0, utk = 0;
    logic [31:0] rpc = 0, upc = 0, utgt = 0;
    logic [31:0] pc, pc4, ptgt;
    logic        pt;
    int          checks = 0, failures = 0;

    logic [31:0] m_pc = 0;
    bit          m_valid [8];
    logic [31:0] m_tag [8];
    logic [31:0] m_tgt [8];
    int          m_ctr [8];

    typedef struct {
        bit          rst, stall, exc, rv;
        logic [31:0] rpc, exp_pc;
        bit          exp_pt;
    } vec_t;
    vec_t tbl [14];

    pc_predict_unit dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_exc_req(exc),
        .i_redirect_valid(rv), .i_redirect_pc(rpc),
        .i_upd_valid(uv), .i_upd_pc(upc), .i_upd_target(utgt), .i_upd_taken(utk),
        .o_pc(pc), .o_pc4(pc4), .o_pred_taken(pt), .o_pred_target(ptgt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model prediction: slot = word address mod 8, tag = address / 32, predict when counter >= 2.
    task automatic predict(input logic [31:0] p, output bit t, output logic [31:0] g);
        int s;
        s = int'((p >> 2) % 8);
        t = m_valid[s] && (m_tag[s] == (p >> 5)) && (m_ctr[s] >= 2);
        g = t ? m_tgt[s] : p + 32'd4;
    endtask

    task automatic cycle();
        bit          t;
        logic [31:0] g, nxt;
        int          s;
        predict(m_pc, t, g);
        nxt = !rst ? 32'h0 : exc ? 32'h80000004 : rv ? rpc : stall ? m_pc : t ? g : m_pc + 32'd4;
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 0;
        end else if (uv) begin
            s = int'((upc >> 2) % 8);
            if (m_valid[s] && m_tag[s] == (upc >> 5)) begin
                if (utk) begin
                    m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                    m_tgt[s] = utgt;
                end else m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
            end else if (utk) begin
                m_valid[s] = 1;
                m_tag[s]   = upc >> 5;
                m_tgt[s]   = utgt;
                m_ctr[s]   = 2;
            end
        end
        m_pc = nxt;
        predict(m_pc, t, g);
        chk("model_pc", pc, m_pc);
        chk("model_pc4", pc4, m_pc + 32'd4);
        chk("model_pred_taken", {31'b0, pt}, {31'b0, t});
        chk("model_pred_target", ptgt, g);
    endtask

    task automatic idle();
        rst = 1; stall = 0; exc = 0; rv = 0; uv = 0; utk = 0; rpc = 0; upc = 0; utgt = 0;
    endtask

    task automatic redirect(input logic [31:0] a);
        idle();
        rv = 1; rpc = a;
        cycle();
        idle();
    endtask

    task automatic train(input logic [31:0] a, input logic [31:0] tg, input bit tk);
        idle();
        uv = 1; upc = a; utgt = tg; utk = tk;
        cycle();
        idle();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        tbl[0]  = '{0, 0, 0, 0, 32'h0,   32'h0,        0};
        tbl[1]  = '{0, 0, 0, 0, 32'h0,   32'h0,        0};
        tbl[2]  = '{1, 0, 0, 0, 32'h0,   32'h4,        0};
        tbl[3]  = '{1, 0, 0, 0, 32'h0,   32'h8,        0};
        tbl[4]  = '{1, 0, 0, 0, 32'h0,   32'hC,        0};
        tbl[5]  = '{1, 0, 0, 0, 32'h0,   32'h10,       0};
        tbl[6]  = '{1, 1, 0, 0, 32'h0,   32'h10,       0};
        tbl[7]  = '{1, 1, 0, 1, 32'h40,  32'h40,       0};
        tbl[8]  = '{1, 1, 0, 0, 32'h0,   32'h40,       0};
        tbl[9]  = '{1, 1, 0, 0, 32'h0,   32'h40,       0};
        tbl[10] = '{1, 0, 0, 0, 32'h0,   32'h44,       0};
        tbl[11] = '{1, 0, 1, 1, 32'h100, 32'h80000004, 0};
        tbl[12] = '{1, 0, 0, 0, 32'h0,   32'h80000008, 0};
        tbl[13] = '{1, 0, 0, 1, 32'h100, 32'h100,      0};
        for (int i = 0; i < 14; i++) begin
            idle();
            rst = tbl[i].rst; stall = tbl[i].stall; exc = tbl[i].exc; rv = tbl[i].rv; rpc = tbl[i].rpc;
            cycle();
            chk("tbl_pc", pc, tbl[i].exp_pc);
            chk("tbl_pred_taken", {31'b0, pt}, {31'b0, tbl[i].exp_pt});
        end

        // Train a taken branch while redirecting, then fetch sequentially into it.
        idle();
        rv = 1; rpc = 32'h10; uv = 1; upc = 32'h20; utgt = 32'h80; utk = 1;
        cycle();
        idle();
        repeat (4) cycle();
        chk("btb_hit_pc", pc, 32'h20);
        chk("btb_hit_taken", {31'b0, pt}, 32'h1);
        chk("btb_hit_target", ptgt, 32'h80);
        cycle();
        chk("btb_follow", pc, 32'h80);
        train(32'h20, 32'h0, 0);
        train(32'h20, 32'h0, 0);
        redirect(32'h20);
        chk("btb_weakened_taken", {31'b0, pt}, 32'h0);
        chk("btb_weakened_target", ptgt, 32'h24);
        cycle();
        chk("btb_weakened_next", pc, 32'h24);

        // Aliasing: 0x20 and 0x40 share a slot, the later allocation evicts the earlier.
        train(32'h20, 32'h80, 1);
        train(32'h40, 32'hC0, 1);
        redirect(32'h20);
        chk("alias_evicted", {31'b0, pt}, 32'h0);
        redirect(32'h40);
        chk("alias_new_taken", {31'b0, pt}, 32'h1);
        chk("alias_new_target", ptgt, 32'hC0);
        cycle();
        chk("alias_follow", pc, 32'hC0);

        // Wrap of pc+4 at the top of the address space.
        redirect(32'hFFFFFFFC);
        chk("wrap_pc4", pc4, 32'h0);
        cycle();
        chk("wrap_next", pc, 32'h0);

        // Reset concurrent with a training request must win and leave the BTB empty.
        idle();
        rst = 0; uv = 1; upc = 32'h80; utgt = 32'h200; utk = 1; stall = 1; rv = 1; rpc = 32'h300;
        cycle();
        idle();
        chk("rst_pc", pc, 32'h0);
        redirect(32'h80);
        chk("rst_blocks_train", {31'b0, pt}, 32'h0);
        redirect(32'h40);
        chk("rst_clears_btb", {31'b0, pt}, 32'h0);

        // Random traffic over a small address window so BTB hits and aliases are frequent.
        repeat (3000) begin
            rst   = ($urandom % 64) != 0;
            stall = ($urandom % 4) == 0;
            exc   = ($urandom % 40) == 0;
            rv    = ($urandom % 8) == 0;
            rpc   = ($urandom % 16 == 0) ? $urandom : $urandom_range(0, 255);
            uv    = ($urandom % 2) == 0;
            utk   = ($urandom % 3) != 0;
            upc   = $urandom_range(0, 255) | (($urandom % 4 == 0) ? 32'h1000 : 32'h0);
            utgt  = $urandom_range(0, 255);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
